// File: rtl/cic_pkg.sv
// Shared CIC package.
// Purpose : default data widths and the scale/round/saturate helper used by
//           the comb-decimate back end and any later CIC interpolator.
// Contents: CIC_ACC_WIDTH / CIC_OUT_WIDTH defaults, sat_res_t, sat_round().
package cic_pkg;

  localparam int unsigned CIC_ACC_WIDTH = 20;
  localparam int unsigned CIC_OUT_WIDTH = 16;

  // Working width for sat_round; wide enough for any accumulator plus the
  // rounding carry, so results are identical to ACC_WIDTH+1-bit arithmetic.
  localparam int unsigned SR_W = 64;

  typedef struct packed {
    logic signed [SR_W-1:0] value;
    logic                   sat;
  } sat_res_t;

  // Round half up, arithmetic right shift by sh, clamp to a signed out_w range.
  function automatic sat_res_t sat_round(input logic signed [SR_W-1:0] x,
                                         input logic [4:0]              sh,
                                         input int unsigned             out_w);
    logic signed [SR_W-1:0] rnd;
    logic signed [SR_W-1:0] t;
    logic signed [SR_W-1:0] sh_v;
    logic signed [SR_W-1:0] max_v;
    logic signed [SR_W-1:0] min_v;
    sat_res_t               r;
    rnd   = (sh == 5'd0) ? 64'sd0 : signed'(64'd1 << (sh - 5'd1));
    t     = x + rnd;
    sh_v  = t >>> sh;
    max_v = signed'((64'd1 << (out_w - 1)) - 64'd1);
    min_v = -max_v - 64'sd1;
    r.value = sh_v;
    r.sat   = 1'b0;
    if (sh_v > max_v) begin
      r.value = max_v;
      r.sat   = 1'b1;
    end else if (sh_v < min_v) begin
      r.value = min_v;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_comb_decim_if.sv
// Data/control bundle of the CIC comb-decimate back end.
// master: drives flush, valid_in, comb_in, dec_ratio, shift;
//         receives valid_out, comb_out, sat_flag.
// slave : the decimator side of the same signals.
interface cic_comb_decim_if
  import cic_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = CIC_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH  = CIC_OUT_WIDTH,
  parameter int unsigned RATE_WIDTH = 8
);
  logic                        flush;
  logic                        valid_in;
  logic signed [ACC_WIDTH-1:0] comb_in;
  logic [RATE_WIDTH-1:0]       dec_ratio;
  logic [4:0]                  shift;
  logic                        valid_out;
  logic signed [OUT_WIDTH-1:0] comb_out;
  logic                        sat_flag;

  modport master (
    output flush, valid_in, comb_in, dec_ratio, shift,
    input  valid_out, comb_out, sat_flag
  );

  modport slave (
    input  flush, valid_in, comb_in, dec_ratio, shift,
    output valid_out, comb_out, sat_flag
  );
endinterface

// File: rtl/cic_comb_decim_comb_stage.sv
// comb_stage: one registered differentiator (M = 1).
// Ports: clk, rst_n (async, active-low), flush (sync clear),
//        valid_in/x   - input sample and qualifier,
//        valid_out/y  - registered y = x - x_prev, wrapping at W bits.
// x_prev only advances on qualified samples, so gaps do not disturb state.
module comb_stage
  import cic_pkg::*;
#(
  parameter int unsigned W = CIC_ACC_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                valid_in,
  input  logic signed [W-1:0] x,
  output logic                valid_out,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] x_prev_q, x_prev_d;
  logic signed [W-1:0] y_q, y_d;
  logic                valid_q, valid_d;

  always_comb begin
    x_prev_d = x_prev_q;
    y_d      = y_q;
    valid_d  = 1'b0;
    if (flush) begin
      x_prev_d = '0;
      y_d      = '0;
    end else if (valid_in) begin
      x_prev_d = x;
      y_d      = x - x_prev_q;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev_q <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      x_prev_q <= x_prev_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
    end
  end

  assign valid_out = valid_q;
  assign y         = y_q;

endmodule

// File: rtl/cic_comb_decim.sv
// cic_comb_decim: comb-and-decimate back end of the CIC decimator.
// Ports: clk, rst_n (async, active-low), bus (cic_comb_decim_if.slave):
//   flush, valid_in, comb_in, dec_ratio, shift  -> in
//   valid_out, comb_out, sat_flag               -> out
// Pipeline: input capture register (keeps 1 in R), N_STAGES comb stages,
// then one scaler register (round, shift, saturate).
module cic_comb_decim
  import cic_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = CIC_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH  = CIC_OUT_WIDTH,
  parameter int unsigned N_STAGES   = 3,
  parameter int unsigned RATE_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cic_comb_decim_if.slave bus
);

  // Decimation counter, latched ratio and input capture register.
  logic [RATE_WIDTH-1:0]       cnt_q, cnt_d;
  logic [RATE_WIDTH-1:0]       r_q, r_d;
  logic                        in_valid_q, in_valid_d;
  logic signed [ACC_WIDTH-1:0] in_data_q, in_data_d;
  logic [RATE_WIDTH-1:0]       ratio_eff;

  assign ratio_eff = (bus.dec_ratio == '0) ? RATE_WIDTH'(1) : bus.dec_ratio;

  always_comb begin
    cnt_d      = cnt_q;
    r_d        = r_q;
    in_valid_d = 1'b0;
    in_data_d  = in_data_q;
    if (bus.flush) begin
      cnt_d     = '0;
      r_d       = RATE_WIDTH'(1);
      in_data_d = '0;
    end else if (bus.valid_in) begin
      if (cnt_q == '0) begin
        // Accepting a sample is the only point where a new ratio is taken.
        in_valid_d = 1'b1;
        in_data_d  = bus.comb_in;
        r_d        = ratio_eff;
        cnt_d      = (ratio_eff == RATE_WIDTH'(1)) ? '0 : RATE_WIDTH'(1);
      end else begin
        cnt_d = (cnt_q == r_q - RATE_WIDTH'(1)) ? '0 : cnt_q + RATE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      r_q        <= RATE_WIDTH'(1);
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      in_valid_q <= in_valid_d;
      in_data_q  <= in_data_d;
    end
  end

  // Comb chain: element 0 is the capture register, element k is stage k.
  logic [N_STAGES:0]           stage_v;
  logic signed [ACC_WIDTH-1:0] stage_x [N_STAGES+1];

  assign stage_v[0] = in_valid_q;
  assign stage_x[0] = in_data_q;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
    comb_stage #(.W(ACC_WIDTH)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.flush),
      .valid_in  (stage_v[k]),
      .x         (stage_x[k]),
      .valid_out (stage_v[k+1]),
      .y         (stage_x[k+1])
    );
  end

  // Scaler register; shift is taken live in this cycle.
  logic signed [SR_W-1:0]      y_ext;
  sat_res_t                    res;
  logic                        unused_hi;
  logic                        out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                        sat_q, sat_d;

  assign y_ext     = {{(SR_W-ACC_WIDTH){stage_x[N_STAGES][ACC_WIDTH-1]}}, stage_x[N_STAGES]};
  assign unused_hi = ^res.value[SR_W-1:OUT_WIDTH];

  always_comb begin
    res         = sat_round(y_ext, bus.shift, OUT_WIDTH);
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    sat_d       = 1'b0;
    if (bus.flush) begin
      out_data_d = '0;
    end else if (stage_v[N_STAGES]) begin
      out_valid_d = 1'b1;
      out_data_d  = res.value[OUT_WIDTH-1:0];
      sat_d       = res.sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.valid_out = out_valid_q;
  assign bus.comb_out  = out_data_q;
  assign bus.sat_flag  = sat_q;

endmodule
